// File: rtl/mealy_stream_scheduler_pkg.sv
// Shared types and defaults for the Mealy stream scheduler.
package mealy_sched_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DRAIN,
        S_RESP
    } state_e;

    function automatic int wrap_add(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/mealy_stream_scheduler_if.sv
// Requester/response bus between the requester fabric and the scheduler.
interface mealy_stream_scheduler_if
    import mealy_sched_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int W   = DEF_W,
    parameter int IDW = $clog2(N)
) ();

    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic           resp_ready;
    logic [W-1:0]   resp_data;
    logic [IDW-1:0] resp_id;

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id
    );

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id
    );

endinterface

// File: rtl/mealy_stream_scheduler_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr_i, wrapping to index 0.
module rr_arbiter
    import mealy_sched_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   grant_onehot_o,
    output logic [IDW-1:0] grant_idx_o,
    output logic           any_o
);

    logic [IDW-1:0] cand;

    always_comb begin
        grant_onehot_o = '0;
        grant_idx_o    = '0;
        any_o          = 1'b0;
        cand           = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDW'(wrap_add(int'(ptr_i), i, N));
            if (!any_o && req_i[cand]) begin
                any_o                = 1'b1;
                grant_idx_o          = cand;
                grant_onehot_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mealy_stream_scheduler.sv
// Time-shares one serial Mealy detector among N requesters, one word per grant.
//  state | meaning
//  IDLE  | waiting for a request; grant is combinational from req_valid
//  CLEAR | one-cycle reset pulse to the detector
//  SHIFT | W cycles driving word bits LSB-first, capturing previous bit's output
//  DRAIN | capture the detector output for the last bit
//  RESP  | hold result until the consumer accepts it
module mealy_stream_scheduler
    import mealy_sched_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int W   = DEF_W,
    parameter int IDW = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     reset,
    mealy_stream_scheduler_if.slave  bus,
    output logic                     det_reset_o,
    output logic                     det_in_o,
    input  logic                     det_out_i,
    output logic                     busy_o
);

    localparam int CW = $clog2(W + 1);

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   word_q, word_d;
    logic [W-1:0]   result_q, result_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [N-1:0]   grant_onehot;
    logic [IDW-1:0] grant_idx;
    logic           grant_any;

    rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
        .req_i          (bus.req_valid),
        .ptr_i          (rr_ptr_q),
        .grant_onehot_o (grant_onehot),
        .grant_idx_o    (grant_idx),
        .any_o          (grant_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            word_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            word_q   <= word_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        id_d           = id_q;
        word_d         = word_q;
        result_d       = result_q;
        cnt_d          = cnt_q;
        bus.req_ready  = '0;
        bus.resp_valid = 1'b0;
        det_reset_o    = 1'b0;
        det_in_o       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    bus.req_ready = grant_onehot;
                    word_d        = bus.req_data[grant_idx*W +: W];
                    id_d          = grant_idx;
                    rr_ptr_d      = IDW'(wrap_add(int'(grant_idx), 1, N));
                    state_d       = S_CLEAR;
                end
            end
            S_CLEAR: begin
                det_reset_o = 1'b1;
                cnt_d       = '0;
                state_d     = S_SHIFT;
            end
            S_SHIFT: begin
                det_in_o = word_q[0];
                word_d   = word_q >> 1;
                // Output for bit c-1 arrives during bit c; the first bit has nothing to capture yet.
                if (cnt_q != '0) begin
                    result_d = {det_out_i, result_q[W-1:1]};
                end
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                result_d = {det_out_i, result_q[W-1:1]};
                state_d  = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (reset) begin
            bus.req_ready  = '0;
            bus.resp_valid = 1'b0;
            det_reset_o    = 1'b1;
            det_in_o       = 1'b0;
        end
    end

    assign bus.resp_data = result_q;
    assign bus.resp_id   = id_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_mealy_stream_scheduler.sv
// Directed bench for mealy_stream_scheduler with a frame-level reference model and detector model.
module tb_mealy_stream_scheduler;
    import mealy_sched_pkg::*;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic det_reset, det_in, det_out, busy;
    logic det_s;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mealy_stream_scheduler_if #(.N(N), .W(W), .IDW(IDW)) bus ();

    mealy_stream_scheduler #(.N(N), .W(W), .IDW(IDW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .det_reset_o (det_reset),
        .det_in_o    (det_in),
        .det_out_i   (det_out),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared detector: registered out = s & in, s toggles on every 1.
    always @(posedge clk) begin
        if (det_reset) begin
            det_s   <= 1'b0;
            det_out <= 1'b0;
        end else begin
            det_out <= det_s & det_in;
            det_s   <= det_s ^ det_in;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [W-1:0] det_ref(input logic [W-1:0] word);
        logic s;
        logic [W-1:0] r;
        s = 1'b0;
        r = '0;
        for (int k = 0; k < W; k++) begin
            r[k] = s & word[k];
            s    = s ^ word[k];
        end
        return r;
    endfunction

    // Frame-level model: one outstanding frame, timing derived from handshake cycle.
    bit           m_busy = 1'b0;
    int           m_ptr = 0;
    int           m_hs = 0;
    logic [W-1:0] m_word = '0;
    int           m_id = 0;
    logic [W-1:0] rsp_log[$];

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        logic         exp_dr, exp_di, exp_rv;
        int           g;
        if (reset) begin
            check("rst_det_reset", det_reset, 1'b1);
            check("rst_det_in", det_in, 1'b0);
            check("rst_req_ready", bus.req_ready, '0);
            check("rst_resp_valid", bus.resp_valid, 1'b0);
            m_busy = 1'b0;
            m_ptr  = 0;
        end else begin
            exp_rdy = '0;
            g = -1;
            if (!m_busy) begin
                for (int i = 0; i < N; i++) begin
                    if (g < 0 && bus.req_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", bus.req_ready, exp_rdy);
            check("busy", busy, m_busy);

            exp_dr = m_busy && (cyc == m_hs + 1);
            exp_di = 1'b0;
            if (m_busy && cyc >= m_hs + 2 && cyc <= m_hs + 1 + W) exp_di = m_word[cyc - m_hs - 2];
            check("det_reset", det_reset, exp_dr);
            check("det_in", det_in, exp_di);

            exp_rv = m_busy && (cyc >= m_hs + W + 3);
            check("resp_valid", bus.resp_valid, exp_rv);
            if (exp_rv) begin
                check("resp_data", bus.resp_data, det_ref(m_word));
                check("resp_id", bus.resp_id, m_id);
                if (bus.resp_ready) begin
                    rsp_log.push_back(bus.resp_data);
                    m_busy = 1'b0;
                end
            end

            if (g >= 0) begin
                m_busy = 1'b1;
                m_hs   = cyc;
                m_word = bus.req_data[g*W +: W];
                m_id   = g;
                m_ptr  = (g + 1) % N;
            end
        end
    end

    task automatic wait_hs(input int idx, output int c);
        c = -1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.req_ready[idx] && bus.req_valid[idx]) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) timeout("handshake");
    endtask

    task automatic wait_resp(output int c, output logic [W-1:0] d, output int id);
        c = -1;
        d = '0;
        id = 0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.resp_valid && bus.resp_ready) begin
                c  = cyc;
                d  = bus.resp_data;
                id = bus.resp_id;
                break;
            end
        end
        if (c < 0) timeout("response");
    endtask

    task automatic run_one(input int idx, input logic [W-1:0] data, input logic [W-1:0] exp);
        int hc, rc, id;
        logic [W-1:0] d;
        bus.req_valid[idx]        = 1'b1;
        bus.req_data[idx*W +: W]  = data;
        wait_hs(idx, hc);
        @(posedge clk); #1;
        bus.req_valid[idx]        = 1'b0;
        bus.req_data[idx*W +: W]  = ~data;
        wait_resp(rc, d, id);
        check("lit_latency", rc - hc, W + 3);
        check("lit_data", d, exp);
        check("lit_id", id, idx);
        @(posedge clk); #1;
    endtask

    initial begin
        int h1, h2, rc, id;
        logic [W-1:0] d;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.resp_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("init_busy", busy, 1'b0);
        check("init_resp_valid", bus.resp_valid, 1'b0);
        check("init_resp_data", bus.resp_data, 8'h00);
        check("init_resp_id", bus.resp_id, 2'd0);
        check("init_det_reset", det_reset, 1'b0);
        @(posedge clk); #1;

        // Single words from each requester.
        run_one(0, 8'hFF, 8'hAA);
        run_one(1, 8'h03, 8'h02);
        run_one(2, 8'h05, 8'h04);
        run_one(3, 8'h00, 8'h00);

        // All four valid from reset: strict rotation.
        reset = 1'b1;
        bus.req_valid = 4'hF;
        bus.req_data  = {8'h00, 8'h05, 8'h03, 8'hFF};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        rsp_log.delete();
        for (int k = 0; k < 5; k++) begin
            h1 = -1;
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                if (bus.req_ready != '0) begin
                    h1 = cyc;
                    break;
                end
            end
            if (h1 < 0) timeout("rotation");
            check("rot_grant", bus.req_ready, 4'b0001 << (k % 4));
            @(negedge clk);
            check("rot_one_cycle", bus.req_ready, 4'b0000);
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_resp(rc, d, id);
        check("rot_last_data", d, 8'hAA);
        @(posedge clk); #1;
        check("rot_log_size", rsp_log.size(), 5);
        if (rsp_log.size() == 5) begin
            check("rot_log1", rsp_log[1], 8'h02);
            check("rot_log2", rsp_log[2], 8'h04);
            check("rot_log3", rsp_log[3], 8'h00);
        end

        // Backpressure in RESP.
        bus.resp_ready = 1'b0;
        bus.req_valid[2] = 1'b1;
        bus.req_data[2*W +: W] = 8'h05;
        wait_hs(2, h1);
        @(posedge clk); #1;
        bus.req_valid[2] = 1'b0;
        bus.req_valid[0] = 1'b1;
        bus.req_data[0 +: W] = 8'h03;
        h2 = -1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                h2 = cyc;
                break;
            end
        end
        if (h2 < 0) timeout("bp_resp_valid");
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            check("bp_data", bus.resp_data, 8'h04);
            check("bp_id", bus.resp_id, 2'd2);
            check("bp_ready", bus.req_ready, 4'b0000);
            check("bp_det", {det_reset, det_in}, 2'b00);
        end
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        wait_hs(0, h1);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_resp(rc, d, id);
        check("bp_next_data", d, 8'h02);
        check("bp_next_id", id, 0);
        @(posedge clk); #1;

        // Reset during SHIFT bit 3 aborts the frame and resets the pointer.
        bus.req_valid[1] = 1'b1;
        bus.req_data[1*W +: W] = 8'hFF;
        wait_hs(1, h1);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_resp_valid", bus.resp_valid, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 4'b1001;
        bus.req_data[0 +: W]   = 8'hFF;
        bus.req_data[3*W +: W] = 8'h00;
        @(negedge clk);
        check("abort_ptr_grant", bus.req_ready, 4'b0001);
        @(posedge clk); #1;
        bus.req_valid = '0;
        wait_resp(rc, d, id);
        check("abort_next_data", d, 8'hAA);
        check("abort_next_id", id, 0);
        @(posedge clk); #1;

        // Back-to-back frames from one requester.
        rsp_log.delete();
        bus.req_valid[3] = 1'b1;
        bus.req_data[3*W +: W] = 8'hFF;
        wait_hs(3, h1);
        @(posedge clk); #1;
        wait_hs(3, h2);
        check("b2b_interval", h2 - h1, W + 4);
        @(posedge clk); #1;
        bus.req_valid[3] = 1'b0;
        wait_resp(rc, d, id);
        check("b2b_data2", d, 8'hAA);
        @(posedge clk); #1;
        check("b2b_log_size", rsp_log.size(), 2);
        if (rsp_log.size() == 2) check("b2b_data1", rsp_log[0], 8'hAA);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
